// File: rtl/alu_op_sequencer.sv
// Multi-cycle command front end for a 16-bit ALU: register file, operand issue,
// result capture with writeback, and a valid/ready result return.
module alu_op_sequencer #(
    parameter int DATA_W = 16,
    parameter int NREG   = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [3:0]        cmd_select,
    input  logic [AW-1:0]     cmd_src_a,
    input  logic [AW-1:0]     cmd_src_b,
    input  logic [AW-1:0]     cmd_dst,
    input  logic              cmd_use_carry,
    input  logic              cmd_wb,
    output logic [DATA_W-1:0] alu_in_a,
    output logic [DATA_W-1:0] alu_in_b,
    output logic [3:0]        alu_select,
    output logic              alu_mode,
    output logic              alu_carry_in,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry_out,
    input  logic              alu_compare,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry,
    output logic              res_compare,
    output logic              carry_flag,
    output logic [15:0]       ops_done
);

    // state   | meaning
    // IDLE    | ready for a command; operands latched on accept
    // ISSUE   | ALU inputs stable, ALU settling
    // CAPTURE | ALU result sampled, flags and writeback updated
    // RESP    | result held until res_ready
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [NREG];
    logic [AW-1:0]     dst_q;
    logic              wb_q;

    assign cmd_ready = (state == IDLE);
    assign rd_data   = regs[rd_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            dst_q        <= '0;
            wb_q         <= 1'b0;
            alu_in_a     <= '0;
            alu_in_b     <= '0;
            alu_select   <= '0;
            alu_mode     <= 1'b0;
            alu_carry_in <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_carry    <= 1'b0;
            res_compare  <= 1'b0;
            carry_flag   <= 1'b0;
            ops_done     <= '0;
        end else begin
            // Load first so a same-address writeback later in this block overrides it.
            if (ld_valid) regs[ld_addr] <= ld_data;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_in_a     <= regs[cmd_src_a];
                        alu_in_b     <= regs[cmd_src_b];
                        alu_select   <= cmd_select;
                        alu_mode     <= cmd_mode;
                        alu_carry_in <= cmd_use_carry ? carry_flag : 1'b0;
                        dst_q        <= cmd_dst;
                        wb_q         <= cmd_wb;
                        state        <= ISSUE;
                    end
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    res_data    <= alu_out;
                    res_carry   <= alu_carry_out;
                    res_compare <= alu_compare;
                    carry_flag  <= alu_carry_out;
                    if (wb_q) regs[dst_q] <= alu_out;
                    res_valid   <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ops_done  <= ops_done + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU attached to the
// alu_* ports; each task drives one scenario and checks against hand-computed values.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid;
    logic [1:0]  ld_addr;
    logic [15:0] ld_data;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic        cmd_valid, cmd_ready, cmd_mode, cmd_use_carry, cmd_wb;
    logic [3:0]  cmd_select;
    logic [1:0]  cmd_src_a, cmd_src_b, cmd_dst;
    logic [15:0] alu_in_a, alu_in_b, alu_out;
    logic [3:0]  alu_select;
    logic        alu_mode, alu_carry_in, alu_carry_out, alu_compare;
    logic        res_valid, res_ready, res_carry, res_compare, carry_flag;
    logic [15:0] res_data, ops_done;

    int checks   = 0;
    int failures = 0;
    int exp_ops  = 0;

    alu_op_sequencer #(.DATA_W(16), .NREG(4), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_select(cmd_select), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_dst(cmd_dst), .cmd_use_carry(cmd_use_carry), .cmd_wb(cmd_wb),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_select(alu_select),
        .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_compare(res_compare),
        .carry_flag(carry_flag), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: logic ops in mode 0 (no carry), true-carry add in mode 1.
    always_comb begin
        alu_out       = '0;
        alu_carry_out = 1'b0;
        alu_compare   = (alu_in_a == alu_in_b);
        if (alu_mode) begin
            if (alu_select == 4'b1001)
                {alu_carry_out, alu_out} = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {16'd0, alu_carry_in};
            else
                {alu_carry_out, alu_out} = {1'b0, alu_in_a} + {16'd0, alu_carry_in};
        end else begin
            case (alu_select)
                4'b0110: alu_out = alu_in_a ^ alu_in_b;
                4'b1011: alu_out = alu_in_a & alu_in_b;
                4'b1110: alu_out = alu_in_a | alu_in_b;
                default: alu_out = ~alu_in_a;
            endcase
        end
    end

    task automatic load(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic set_cmd(input logic m, input logic [3:0] s, input logic [1:0] a,
                           input logic [1:0] b, input logic [1:0] d,
                           input logic uc, input logic wb);
        cmd_mode = m; cmd_select = s; cmd_src_a = a; cmd_src_b = b;
        cmd_dst = d; cmd_use_carry = uc; cmd_wb = wb;
    endtask

    // Returns at the falling edge right after the accepting rising edge.
    task automatic send_cmd(input logic m, input logic [3:0] s, input logic [1:0] a,
                            input logic [1:0] b, input logic [1:0] d,
                            input logic uc, input logic wb);
        @(negedge clk);
        set_cmd(m, s, a, b, d, uc, wb);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // lat = rising edges since the accept edge when res_valid is first seen.
    task automatic wait_res(output int lat);
        lat = 0;
        while (res_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_res;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_ops++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++; if (ops_done !== 16'h0) begin failures++; $display("FAIL reset_ops_done got=%h exp=0000", ops_done); end
        checks++; if (carry_flag !== 1'b0) begin failures++; $display("FAIL reset_carry_flag got=%b exp=0", carry_flag); end
        checks++; if (alu_in_a !== 16'h0) begin failures++; $display("FAIL reset_alu_in_a got=%h exp=0000", alu_in_a); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL reset_reg%0d got=%h exp=0000", i, rd_data); end
        end
    endtask

    task automatic test_logic_xor;
        int lat;
        load(2'd0, 16'h00F0);
        load(2'd1, 16'h0F0F);
        send_cmd(1'b0, 4'b0110, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1);
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL xor_busy got=%b exp=0", cmd_ready); end
        wait_res(lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL xor_latency got=%0d exp=2", lat); end
        checks++; if (res_data !== 16'h0FFF) begin failures++; $display("FAIL xor_res_data got=%h exp=0fff", res_data); end
        rd_addr = 2'd2;
        #1;
        checks++; if (rd_data !== 16'h0FFF) begin failures++; $display("FAIL xor_wb got=%h exp=0fff", rd_data); end
        take_res();
        checks++; if (ops_done !== 16'd1) begin failures++; $display("FAIL xor_ops_done got=%0d exp=1", ops_done); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL xor_idle got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_carry_chain;
        int lat;
        load(2'd0, 16'hFFFF);
        load(2'd1, 16'h0001);
        send_cmd(1'b1, 4'b1001, 2'd0, 2'd1, 2'd3, 1'b0, 1'b1);
        checks++; if (alu_carry_in !== 1'b0) begin failures++; $display("FAIL c1_carry_in got=%b exp=0", alu_carry_in); end
        wait_res(lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL c1_latency got=%0d exp=2", lat); end
        checks++; if (res_data !== 16'h0000) begin failures++; $display("FAIL c1_res_data got=%h exp=0000", res_data); end
        checks++; if (res_carry !== 1'b1) begin failures++; $display("FAIL c1_res_carry got=%b exp=1", res_carry); end
        checks++; if (carry_flag !== 1'b1) begin failures++; $display("FAIL c1_carry_flag got=%b exp=1", carry_flag); end
        take_res();
        send_cmd(1'b1, 4'b1001, 2'd0, 2'd1, 2'd3, 1'b1, 1'b1);
        checks++; if (alu_carry_in !== 1'b1) begin failures++; $display("FAIL c2_carry_in got=%b exp=1", alu_carry_in); end
        wait_res(lat);
        checks++; if (res_data !== 16'h0001) begin failures++; $display("FAIL c2_res_data got=%h exp=0001", res_data); end
        checks++; if (res_carry !== 1'b1) begin failures++; $display("FAIL c2_res_carry got=%b exp=1", res_carry); end
        take_res();
        // a logic-mode op produces carry 0 and must clear the sticky flag
        send_cmd(1'b0, 4'b0110, 2'd0, 2'd1, 2'd3, 1'b0, 1'b0);
        wait_res(lat);
        checks++; if (carry_flag !== 1'b0) begin failures++; $display("FAIL mode0_carry_flag got=%b exp=0", carry_flag); end
        rd_addr = 2'd3;
        #1;
        checks++; if (rd_data !== 16'h0001) begin failures++; $display("FAIL nowb_r3 got=%h exp=0001", rd_data); end
        take_res();
    endtask

    task automatic test_backpressure;
        int lat;
        send_cmd(1'b0, 4'b0110, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0);
        wait_res(lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                set_cmd(1'b1, 4'b1001, 2'd0, 2'd0, 2'd1, 1'b0, 1'b1);
                cmd_valid = 1'b1;
            end
            @(negedge clk);
            cmd_valid = 1'b0;
            checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, res_valid); end
            checks++; if (res_data !== 16'hFFFE) begin failures++; $display("FAIL bp_data cyc=%0d got=%h exp=fffe", i, res_data); end
            checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, cmd_ready); end
        end
        take_res();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_idle got=%b exp=1", cmd_ready); end
        repeat (4) @(negedge clk);
        checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_dropped valid=%b ready=%b exp valid=0 ready=1", res_valid, cmd_ready); end
        checks++; if (ops_done !== 16'(exp_ops)) begin failures++; $display("FAIL bp_ops_done got=%0d exp=%0d", ops_done, exp_ops); end
        rd_addr = 2'd1;
        #1;
        checks++; if (rd_data !== 16'h0001) begin failures++; $display("FAIL bp_r1 got=%h exp=0001", rd_data); end
    endtask

    task automatic test_collision;
        int lat;
        load(2'd0, 16'h1234);
        load(2'd1, 16'h0000);
        // same-address load on the CAPTURE edge: writeback wins
        send_cmd(1'b0, 4'b0110, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1);
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 2'd2; ld_data = 16'hAAAA;
        @(negedge clk);
        ld_valid = 1'b0;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL col_valid got=%b exp=1", res_valid); end
        rd_addr = 2'd2;
        #1;
        checks++; if (rd_data !== 16'h1234) begin failures++; $display("FAIL col_same got=%h exp=1234", rd_data); end
        take_res();
        // different address on the CAPTURE edge: both land
        load(2'd2, 16'h0000);
        send_cmd(1'b0, 4'b0110, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1);
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 2'd3; ld_data = 16'h5555;
        @(negedge clk);
        ld_valid = 1'b0;
        rd_addr = 2'd3;
        #1;
        checks++; if (rd_data !== 16'h5555) begin failures++; $display("FAIL col_diff_ld got=%h exp=5555", rd_data); end
        rd_addr = 2'd2;
        #1;
        checks++; if (rd_data !== 16'h1234) begin failures++; $display("FAIL col_diff_wb got=%h exp=1234", rd_data); end
        wait_res(lat);
        take_res();
    endtask

    task automatic test_compare_only;
        int lat;
        load(2'd0, 16'h5A5A);
        load(2'd1, 16'h5A5A);
        load(2'd3, 16'h7777);
        send_cmd(1'b0, 4'b0110, 2'd0, 2'd1, 2'd3, 1'b0, 1'b0);
        wait_res(lat);
        checks++; if (res_compare !== 1'b1) begin failures++; $display("FAIL cmp_flag got=%b exp=1", res_compare); end
        checks++; if (res_data !== 16'h0000) begin failures++; $display("FAIL cmp_data got=%h exp=0000", res_data); end
        rd_addr = 2'd3;
        #1;
        checks++; if (rd_data !== 16'h7777) begin failures++; $display("FAIL cmp_dst got=%h exp=7777", rd_data); end
        take_res();
    endtask

    task automatic test_operand_latch;
        int lat;
        // r0 = r1 = 5A5A here; load r0 on the accept edge, r1 on the ISSUE edge
        @(negedge clk);
        set_cmd(1'b0, 4'b0110, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1);
        cmd_valid = 1'b1;
        ld_valid = 1'b1; ld_addr = 2'd0; ld_data = 16'h1111;
        @(negedge clk);
        cmd_valid = 1'b0;
        ld_addr = 2'd1; ld_data = 16'h2222;
        checks++; if (alu_in_a !== 16'h5A5A) begin failures++; $display("FAIL raw_in_a got=%h exp=5a5a", alu_in_a); end
        @(negedge clk);
        ld_valid = 1'b0;
        wait_res(lat);
        checks++; if (res_data !== 16'h0000) begin failures++; $display("FAIL latch_res got=%h exp=0000", res_data); end
        rd_addr = 2'd0;
        #1;
        checks++; if (rd_data !== 16'h1111) begin failures++; $display("FAIL latch_r0 got=%h exp=1111", rd_data); end
        take_res();
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        set_cmd(1'b0, 4'b0110, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        repeat (16) @(negedge clk);
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        exp_ops += 4;
        checks++; if (ops_done !== 16'(exp_ops)) begin failures++; $display("FAIL b2b_ops got=%0d exp=%0d", ops_done, exp_ops); end
        checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle ready=%b valid=%b exp ready=1 valid=0", cmd_ready, res_valid); end
    endtask

    task automatic test_reset_mid_resp;
        int lat;
        load(2'd1, 16'hFFFF);
        send_cmd(1'b1, 4'b1001, 2'd1, 2'd1, 2'd2, 1'b0, 1'b1);
        wait_res(lat);
        checks++; if (res_valid !== 1'b1 || carry_flag !== 1'b1) begin failures++; $display("FAIL pre_reset valid=%b carry=%b exp 1 1", res_valid, carry_flag); end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_ops = 0;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
        checks++; if (carry_flag !== 1'b0) begin failures++; $display("FAIL rst_carry_flag got=%b exp=0", carry_flag); end
        checks++; if (ops_done !== 16'h0) begin failures++; $display("FAIL rst_ops_done got=%h exp=0000", ops_done); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            checks++; if (rd_data !== 16'h0) begin failures++; $display("FAIL rst_reg%0d got=%h exp=0000", i, rd_data); end
        end
    endtask

    initial begin
        rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        cmd_valid = 1'b0; res_ready = 1'b0;
        set_cmd(1'b0, 4'b0000, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        test_reset();
        test_logic_xor();
        test_carry_chain();
        test_backpressure();
        test_collision();
        test_compare_only();
        test_operand_latch();
        test_back_to_back();
        test_reset_mid_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
